// File: rtl/regfile_alu_engine.sv
// -----------------------------------------------------------------------------
// regfile_alu_engine
//
// Purpose:
//   Register-file / ALU execution unit that sits behind the board switches and
//   buttons. A debounced press of btn_exec runs one instruction:
//   R[rd] <= R[rs1] <op> R[rs2].
//   Execution is a multi-cycle FSM: IDLE -> READ -> EXEC -> WRITE -> DONE.
//   The last result is held and shown one DISP_W-wide slice at a time on led.
//
// Optional feature:
//   ALU_FLAGS_EN - when defined, a {N,Z,C,V} flags register is updated in
//                  WRITE. When undefined, flags is tied to 4'b0000 and no flag
//                  logic exists.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   btn_reset  in   1       synchronous active-low reset
//   btn_exec   in   1       raw execute pushbutton (asynchronous to clk)
//   op         in   3       000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                           101 SL, 110 SRL, 111 SLT
//   rd         in   AW      destination register (R0 writes are discarded)
//   rs1, rs2   in   AW      source registers
//   disp_sel   in   SW      result slice shown on led
//   led        out  DISP_W  result[disp_sel*DISP_W +: DISP_W], 0 if out of range
//   busy       out  1       high from the accepting IDLE cycle through WRITE
//   done       out  1       one-cycle pulse in DONE
//   flags      out  4       {N,Z,C,V} of the last result
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module regfile_alu_engine #(
   parameter int DATA_W       = 32,
   parameter int NREGS        = 16,
   parameter int DISP_W       = 16,
   parameter int DEBOUNCE_CYC = 2,
   localparam int AW          = $clog2(NREGS),
   localparam int NSLICE      = DATA_W / DISP_W,
   localparam int SW          = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
   input  logic              clk,
   input  logic              btn_reset,
   input  logic              btn_exec,
   input  logic [2:0]        op,
   input  logic [AW-1:0]     rd,
   input  logic [AW-1:0]     rs1,
   input  logic [AW-1:0]     rs2,
   input  logic [SW-1:0]     disp_sel,
   output logic [DISP_W-1:0] led,
   output logic              busy,
   output logic              done,
   output logic [3:0]        flags
);

   localparam int SHW = $clog2(DATA_W);
   localparam int CW  = $clog2(DEBOUNCE_CYC) + 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SL  = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WRITE,
      ST_DONE
   } state_t;

   // ---------------------------------------------------------------------------
   // Button path: 2-flop synchroniser, then a debouncer that only changes the
   // accepted level after DEBOUNCE_CYC consecutive samples that disagree with
   // it. req_reg pulses for one cycle on each accepted 0->1 change, so a long
   // hold gives one request and a new press needs an accepted release first.
   // ---------------------------------------------------------------------------
   logic          sync1_reg;
   logic          sync2_reg;
   logic          level_reg;
   logic [CW-1:0] cnt_reg;
   logic          req_reg;

   always_ff @(posedge clk) begin
      if (!btn_reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         level_reg <= 1'b0;
         cnt_reg   <= '0;
         req_reg   <= 1'b0;
      end else begin
         sync1_reg <= btn_exec;
         sync2_reg <= sync1_reg;
         req_reg   <= 1'b0;
         if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
            req_reg   <= sync2_reg;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Execution FSM
   // ---------------------------------------------------------------------------
   state_t state_reg;
   state_t state_next;
   logic   latch_en;

   always_ff @(posedge clk) begin
      if (!btn_reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A request that shows up outside IDLE is simply not looked at, so it is
   // dropped rather than queued.
   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      latch_en   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (req_reg) begin
               latch_en   = 1'b1;
               busy       = 1'b1;
               state_next = ST_READ;
            end
         end
         ST_READ: begin
            busy       = 1'b1;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            busy       = 1'b1;
            state_next = ST_WRITE;
         end
         ST_WRITE: begin
            busy       = 1'b1;
            state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Register file. Each entry resets to its own index, which gives the board
   // a known, useful set of operands right after reset. R0 resets to 0 and is
   // never written.
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] regs_reg [NREGS];
   logic [2:0]        op_reg;
   logic [AW-1:0]     rd_reg;
   logic [AW-1:0]     rs1_reg;
   logic [AW-1:0]     rs2_reg;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] alu_reg;
   logic [DATA_W-1:0] alu_next;
   logic [DATA_W-1:0] result_reg;

   always_ff @(posedge clk) begin
      if (!btn_reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= DATA_W'(i);
         end
      end else if (state_reg == ST_WRITE && rd_reg != '0) begin
         regs_reg[rd_reg] <= alu_reg;
      end
   end

   // Operands are captured in READ, two cycles before WRITE, so rd equal to a
   // source register always sees the old value.
   always_ff @(posedge clk) begin
      if (!btn_reset) begin
         op_reg     <= '0;
         rd_reg     <= '0;
         rs1_reg    <= '0;
         rs2_reg    <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         alu_reg    <= '0;
         result_reg <= '0;
      end else begin
         if (latch_en) begin
            op_reg  <= op;
            rd_reg  <= rd;
            rs1_reg <= rs1;
            rs2_reg <= rs2;
         end
         if (state_reg == ST_READ) begin
            a_reg <= (rs1_reg == '0) ? '0 : regs_reg[rs1_reg];
            b_reg <= (rs2_reg == '0) ? '0 : regs_reg[rs2_reg];
         end
         if (state_reg == ST_EXEC) begin
            alu_reg <= alu_next;
         end
         if (state_reg == ST_WRITE) begin
            result_reg <= alu_reg;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // ALU. ADD and SUB share one adder: SUB is A + ~B + 1.
   // ---------------------------------------------------------------------------
   logic              is_sub;
   logic [DATA_W-1:0] b_inv;
   logic [DATA_W-1:0] sum;
   logic [SHW-1:0]    shamt;
   logic              slt;

   assign is_sub = (op_reg == OP_SUB);
   assign b_inv  = is_sub ? ~b_reg : b_reg;
   assign shamt  = b_reg[SHW-1:0];
   assign slt    = $signed(a_reg) < $signed(b_reg);

`ifdef ALU_FLAGS_EN
   logic [DATA_W:0] sum_ext;
   logic            carry_next;
   logic            ovf_next;
   logic            carry_reg;
   logic            ovf_reg;
   logic [3:0]      flags_reg;

   assign sum_ext = {1'b0, a_reg} + {1'b0, b_inv} + {{DATA_W{1'b0}}, is_sub};
   assign sum     = sum_ext[DATA_W-1:0];

   // For SUB the carry out of A + ~B + 1 is the inverted borrow. Overflow is
   // "both adder inputs share a sign that the sum does not".
   always_comb begin
      carry_next = 1'b0;
      ovf_next   = 1'b0;
      if (op_reg == OP_ADD || op_reg == OP_SUB) begin
         carry_next = sum_ext[DATA_W];
         ovf_next   = (a_reg[DATA_W-1] == b_inv[DATA_W-1]) &&
                      (sum[DATA_W-1] != a_reg[DATA_W-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (!btn_reset) begin
         carry_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         flags_reg <= 4'b0000;
      end else begin
         if (state_reg == ST_EXEC) begin
            carry_reg <= carry_next;
            ovf_reg   <= ovf_next;
         end
         if (state_reg == ST_WRITE) begin
            flags_reg <= {alu_reg[DATA_W-1], (alu_reg == '0), carry_reg, ovf_reg};
         end
      end
   end

   assign flags = flags_reg;
`else
   assign sum   = a_reg + b_inv + {{(DATA_W-1){1'b0}}, is_sub};
   assign flags = 4'b0000;
`endif

   always_comb begin
      alu_next = '0;
      case (op_reg)
         OP_ADD:  alu_next = sum;
         OP_SUB:  alu_next = sum;
         OP_AND:  alu_next = a_reg & b_reg;
         OP_OR:   alu_next = a_reg | b_reg;
         OP_XOR:  alu_next = a_reg ^ b_reg;
         OP_SL:   alu_next = a_reg << shamt;
         OP_SRL:  alu_next = a_reg >> shamt;
         OP_SLT:  alu_next = {{(DATA_W-1){1'b0}}, slt};
         default: alu_next = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // LED slice select. Unused disp_sel codes show 0.
   // ---------------------------------------------------------------------------
   logic [DISP_W-1:0] slice_w [NSLICE];

   generate
      for (genvar gi = 0; gi < NSLICE; gi++) begin : gen_slice
         assign slice_w[gi] = result_reg[gi*DISP_W +: DISP_W];
      end
   endgenerate

   always_comb begin
      led = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (disp_sel == SW'(i)) begin
            led = slice_w[i];
         end
      end
   end

endmodule

// File: tb/tb_regfile_alu_engine.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_alu_engine (DATA_W=32, NREGS=16, DISP_W=16,
// DEBOUNCE_CYC=2). Expected results come from a reference register model and
// ALU function in this file, pushed to a scoreboard queue at press time and
// popped when the DUT pulses done. Build with +define+ALU_FLAGS_EN to also
// check flag values; otherwise flags are expected to read 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_regfile_alu_engine;

   localparam int DATA_W       = 32;
   localparam int NREGS        = 16;
   localparam int DISP_W       = 16;
   localparam int DEBOUNCE_CYC = 2;
   localparam int AW           = 4;
   localparam int SW           = 1;

   logic              clk = 1'b0;
   logic              btn_reset;
   logic              btn_exec;
   logic [2:0]        op;
   logic [AW-1:0]     rd;
   logic [AW-1:0]     rs1;
   logic [AW-1:0]     rs2;
   logic [SW-1:0]     disp_sel;
   logic [DISP_W-1:0] led;
   logic              busy;
   logic              done;
   logic [3:0]        flags;

   always #5 clk = ~clk;

   regfile_alu_engine #(
      .DATA_W       (DATA_W),
      .NREGS        (NREGS),
      .DISP_W       (DISP_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) dut (
      .clk       (clk),
      .btn_reset (btn_reset),
      .btn_exec  (btn_exec),
      .op        (op),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .disp_sel  (disp_sel),
      .led       (led),
      .busy      (busy),
      .done      (done),
      .flags     (flags)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model_r [NREGS];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference ALU: carry and overflow derived from operand values, not from
   // an adder bit.
   function automatic exp_t model_op(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
      exp_t        e;
      logic [32:0] wide;
      logic        c;
      logic        v;
      c = 1'b0;
      v = 1'b0;
      case (o)
         3'd0: begin
            wide  = {1'b0, a} + {1'b0, b};
            e.res = wide[31:0];
            c     = wide[32];
            v     = (a[31] == b[31]) && (e.res[31] != a[31]);
         end
         3'd1: begin
            e.res = a - b;
            c     = (a >= b);
            v     = (a[31] != b[31]) && (e.res[31] != a[31]);
         end
         3'd2: e.res = a & b;
         3'd3: e.res = a | b;
         3'd4: e.res = a ^ b;
         3'd5: e.res = a << b[4:0];
         3'd6: e.res = a >> b[4:0];
         default: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
`ifdef ALU_FLAGS_EN
      e.flg = {e.res[31], (e.res == 32'd0), c, v};
`else
      e.flg = 4'b0000;
`endif
      return e;
   endfunction

   // Button level for cycle k: a first press of h1 cycles, a gap, then an
   // optional second press of h2 cycles.
   function automatic logic pat(input int k, input int h1, input int gap, input int h2);
      return (k < h1) || (k >= h1 + gap && k < h1 + gap + h2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) model_r[i] = 32'(i);
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [AW-1:0] d,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input int h1, input int gap, input int h2);
      exp_t e;
      exp_t got_e;
      int   t_busy;
      int   t_done;
      int   n_busy;
      int   n_done;
      bit   popped;
      t_busy = -1;
      t_done = -1;
      n_busy = 0;
      n_done = 0;
      popped = 1'b0;
      e = model_op(o, model_r[s1], model_r[s2]);
      sb_q.push_back(e);
      if (d != '0) model_r[d] = e.res;
      got_e = e;

      op       = o;
      rd       = d;
      rs1      = s1;
      rs2      = s2;
      disp_sel = 1'b0;
      btn_exec = pat(0, h1, gap, h2);
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (busy) begin
            n_busy++;
            if (t_busy < 0) t_busy = i;
         end
         if (done) begin
            n_done++;
            if (t_done < 0) begin
               t_done = i;
               got_e  = sb_q.pop_front();
               popped = 1'b1;
               check({name, ":led_at_done"}, 32'(led), 32'(got_e.res[15:0]));
            end
         end
         btn_exec = pat(i, h1, gap, h2);
         // The operation is latched at the end of the first busy cycle; from
         // then on the inputs must no longer matter.
         if (t_busy >= 0 && i > t_busy) begin
            op  = 3'($urandom_range(0, 7));
            rd  = 4'($urandom_range(0, 15));
            rs1 = 4'($urandom_range(0, 15));
            rs2 = 4'($urandom_range(0, 15));
         end
         if (t_done >= 0 && i >= t_done + 3 && i >= h1 + gap + h2 + 8) break;
      end
      if (!popped && sb_q.size() > 0) got_e = sb_q.pop_front();

      check({name, ":done_count"}, 32'(n_done), 32'd1);
      check({name, ":busy_cycles"}, 32'(n_busy), 32'd4);
      check({name, ":latency"}, 32'(t_done - t_busy), 32'd4);
      disp_sel = 1'b0;
      #1;
      check({name, ":led0"}, 32'(led), 32'(got_e.res[15:0]));
      disp_sel = 1'b1;
      #1;
      check({name, ":led1"}, 32'(led), 32'(got_e.res[31:16]));
      check({name, ":flags"}, 32'(flags), 32'(got_e.flg));
      disp_sel = 1'b0;
      $display("txn %s op=%0d rd=%0d rs1=%0d rs2=%0d exp=%08h flags_exp=%04b busy=%0d done=%0d",
               name, o, d, s1, s2, got_e.res, got_e.flg, n_busy, n_done);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_busy;
      int n_done;
      int t_busy;
      bit hit;

      btn_reset = 1'b0;
      btn_exec  = 1'b0;
      op        = '0;
      rd        = '0;
      rs1       = '0;
      rs2       = '0;
      disp_sel  = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst:busy", 32'(busy), 32'd0);
      check("rst:done", 32'(done), 32'd0);
      check("rst:led0", 32'(led), 32'd0);
      disp_sel = 1'b1;
      #1;
      check("rst:led1", 32'(led), 32'd0);
      check("rst:flags", 32'(flags), 32'd0);
      disp_sel = 1'b0;
      btn_reset = 1'b1;
      repeat (3) @(negedge clk);

      // Directed op sweep
      run_op("add_r4",   3'd0, 4'd4,  4'd1,  4'd2,  3, 0, 0);
      run_op("sub_r5",   3'd1, 4'd5,  4'd11, 4'd10, 3, 0, 0);
      run_op("sl_r11",   3'd5, 4'd11, 4'd14, 4'd2,  3, 0, 0);
      run_op("srl_r12",  3'd6, 4'd12, 4'd15, 4'd2,  3, 0, 0);
      run_op("slt_r13",  3'd7, 4'd13, 4'd1,  4'd2,  3, 0, 0);
      run_op("sub_neg",  3'd1, 4'd3,  4'd1,  4'd2,  3, 0, 0);
      run_op("slt_neg",  3'd7, 4'd7,  4'd3,  4'd1,  3, 0, 0);
      run_op("add_r0",   3'd0, 4'd0,  4'd1,  4'd2,  3, 0, 0);
      run_op("r0_plus",  3'd0, 4'd15, 4'd0,  4'd0,  3, 0, 0);
      run_op("and_r8",   3'd2, 4'd8,  4'd3,  4'd11, 3, 0, 0);
      run_op("or_r9",    3'd3, 4'd9,  4'd3,  4'd0,  3, 0, 0);
      run_op("xor_r10",  3'd4, 4'd10, 4'd3,  4'd12, 3, 0, 0);
      run_op("add_cry",  3'd0, 4'd2,  4'd3,  4'd3,  3, 0, 0);
      run_op("sl_big",   3'd5, 4'd14, 4'd3,  4'd11, 3, 0, 0);
      run_op("same_reg", 3'd0, 4'd14, 4'd14, 4'd14, 3, 0, 0);
      for (int k = 0; k < 4; k++) begin
         run_op("rand", 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3, 0, 0);
      end

      // One-cycle glitch: no request
      n_busy = 0;
      n_done = 0;
      btn_exec = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         btn_exec = 1'b0;
         if (busy) n_busy++;
         if (done) n_done++;
      end
      check("glitch:busy", 32'(n_busy), 32'd0);
      check("glitch:done", 32'(n_done), 32'd0);
      $display("txn glitch busy_cycles=%0d done_pulses=%0d", n_busy, n_done);

      // Long hold, then a second press that lands while the first is in flight
      run_op("held20",   3'd4, 4'd9, 4'd9, 4'd1, 20, 0, 0);
      run_op("dblpress", 3'd0, 4'd4, 4'd4, 4'd1, 2, 2, 10);
      run_op("chk_r4",   3'd3, 4'd6, 4'd4, 4'd0, 3, 0, 0);

      // Reset asserted while an ADD R4 is in EXEC
      op     = 3'd0;
      rd     = 4'd4;
      rs1    = 4'd1;
      rs2    = 4'd2;
      t_busy = -1;
      hit    = 1'b0;
      btn_exec = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy && t_busy < 0) t_busy = i;
         btn_exec = (i < 2);
         if (t_busy >= 0 && i == t_busy + 2) begin
            hit = 1'b1;
            btn_reset = 1'b0;
            @(negedge clk);
            check("rstx:busy", 32'(busy), 32'd0);
            check("rstx:done", 32'(done), 32'd0);
            disp_sel = 1'b0;
            #1;
            check("rstx:led0", 32'(led), 32'd0);
            disp_sel = 1'b1;
            #1;
            check("rstx:led1", 32'(led), 32'd0);
            check("rstx:flags", 32'(flags), 32'd0);
            disp_sel  = 1'b0;
            btn_reset = 1'b1;
            break;
         end
      end
      check("rstx:reached_exec", 32'(hit), 32'd1);
      model_reset();
      n_busy = 0;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy) n_busy++;
         if (done) n_done++;
      end
      check("rstx:no_done", 32'(n_done), 32'd0);
      check("rstx:no_busy", 32'(n_busy), 32'd0);
      $display("txn reset_in_exec busy_after=%0d done_after=%0d", n_busy, n_done);

      run_op("post_rst", 3'd0, 4'd6, 4'd4, 4'd0, 3, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
